// File: rtl/rv32i_decode_alu_if.sv
// rv32i_decode_alu_if
// Bundles the decode/ALU stage signals so the stage and its driver share one
// connection point.
//   master : drives instruction, rs1_data, rs2_data; observes everything else
//   slave  : the decode/ALU stage itself (consumes operands, produces the
//            decoded fields, ALU result and writeback registers)
// Signals:
//   instruction[31:0], rs1_data[31:0], rs2_data[31:0]   operand side
//   opcode[6:0], rd/rs1/rs2[4:0], funct3[2:0]           decoded fields
//   imm12, imm20, store_offset, branch_offset,
//   jal_offset, jalr_offset [31:0]                      immediates
//   alu_op[3:0], alu_out[31:0], illegal                 ALU side
//   wb_data_q[31:0], wb_rd_q[4:0], wb_en_q              writeback registers
interface rv32i_decode_alu_if;
  logic [31:0] instruction;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm12;
  logic [31:0] imm20;
  logic [31:0] store_offset;
  logic [31:0] branch_offset;
  logic [31:0] jal_offset;
  logic [31:0] jalr_offset;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        illegal;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_en_q;

  modport master (
    output instruction, rs1_data, rs2_data,
    input  opcode, rd, rs1, rs2, funct3,
    input  imm12, imm20, store_offset, branch_offset, jal_offset, jalr_offset,
    input  alu_op, alu_out, illegal,
    input  wb_data_q, wb_rd_q, wb_en_q
  );

  modport slave (
    input  instruction, rs1_data, rs2_data,
    output opcode, rd, rs1, rs2, funct3,
    output imm12, imm20, store_offset, branch_offset, jal_offset, jalr_offset,
    output alu_op, alu_out, illegal,
    output wb_data_q, wb_rd_q, wb_en_q
  );
endinterface

// File: rtl/rv32i_decode_alu.sv
// rv32i_decode_alu
// Instruction decode plus integer ALU for the RV32I core. The instruction is
// sliced into its fields and every immediate form, an ALU operation is derived,
// the result is computed combinationally and then captured, together with the
// destination register and write-enable, into a one-stage writeback register.
// Ports:
//   clock   in   single clock, all state on the rising edge
//   reset   in   synchronous active-high reset (clears the writeback register)
//   bus_io  slave modport of rv32i_decode_alu_if (operands in, decode/ALU and
//           writeback outputs out)
// Configuration:
//   DECODE_ILLEGAL_EN  when defined, opcodes outside the supported RV32I set
//                      raise illegal and are never written back; when
//                      undefined, illegal is tied low.
module rv32i_decode_alu (
  input logic clock,
  input logic reset,
  rv32i_decode_alu_if.slave bus_io
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [31:0] imm12;
  logic [3:0]  alu_op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        illegal;

  logic [31:0] wb_data_d, wb_data_q;
  logic [4:0]  wb_rd_d,   wb_rd_q;
  logic        wb_en_d,   wb_en_q;

  // Field slicing and immediate generation: pure wiring plus sign extension.
  assign instr  = bus_io.instruction;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign imm12  = {{20{instr[31]}}, instr[31:20]};

  assign bus_io.opcode        = opcode;
  assign bus_io.rd            = rd;
  assign bus_io.rs1           = instr[19:15];
  assign bus_io.rs2           = instr[24:20];
  assign bus_io.funct3        = funct3;
  assign bus_io.imm12         = imm12;
  assign bus_io.imm20         = {instr[31:12], 12'b0};
  assign bus_io.store_offset  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign bus_io.branch_offset = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
  assign bus_io.jal_offset    = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
  assign bus_io.jalr_offset   = imm12;

  // ALU operation: bit 3 comes from instruction[30] for register ops, but for
  // immediate ops only on the shift-right group, because there bit 30 is part
  // of the immediate and a negative ADDI must not turn into SUB.
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OPC_OP:     alu_op = {instr[30], funct3};
      OPC_OP_IMM: alu_op = {(funct3 == 3'd5) & instr[30], funct3};
      default:    alu_op = ALU_ADD;
    endcase
  end

  // Second operand is the I-immediate only for OP_IMM; every other opcode
  // feeds rs2_data through.
  assign opA   = bus_io.rs1_data;
  assign opB   = (opcode == OPC_OP_IMM) ? imm12 : bus_io.rs2_data;
  assign shamt = opB[4:0];

  // Integer ALU; unassigned codes produce zero rather than an arbitrary value.
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_out = opA + opB;
      ALU_SUB:  alu_out = opA - opB;
      ALU_SLL:  alu_out = opA << shamt;
      ALU_SRL:  alu_out = opA >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(opA) >>> shamt);
      ALU_SLT:  alu_out = {31'd0, $signed(opA) < $signed(opB)};
      ALU_SLTU: alu_out = {31'd0, opA < opB};
      ALU_XOR:  alu_out = opA ^ opB;
      ALU_OR:   alu_out = opA | opB;
      ALU_AND:  alu_out = opA & opB;
      default:  alu_out = 32'd0;
    endcase
  end

  assign bus_io.alu_op  = alu_op;
  assign bus_io.alu_out = alu_out;

`ifdef DECODE_ILLEGAL_EN
  // Anything outside the nine supported opcodes is flagged.
  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  assign bus_io.illegal = illegal;

  // Only register/immediate ALU ops write the register file, and writes to
  // x0 are suppressed here rather than in the register file.
  assign wb_data_d = alu_out;
  assign wb_rd_d   = rd;
  assign wb_en_d   = ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) &&
                     (rd != 5'd0) && !illegal;

  // Writeback register; reset drops whatever result was in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_data_q <= 32'd0;
      wb_rd_q   <= 5'd0;
      wb_en_q   <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign bus_io.wb_data_q = wb_data_q;
  assign bus_io.wb_rd_q   = wb_rd_q;
  assign bus_io.wb_en_q   = wb_en_q;

endmodule

// File: tb/tb_rv32i_decode_alu.sv
// tb_rv32i_decode_alu
// Directed and randomized checks of the RV32I decode/ALU stage against a
// behavioural model. Honours DECODE_ILLEGAL_EN the same way the design does.
module tb_rv32i_decode_alu;

  logic clock = 1'b0;
  logic reset;

  // 100 MHz free-running clock.
  always #5 clock = ~clock;

  rv32i_decode_alu_if busIf ();

  rv32i_decode_alu dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (busIf)
  );

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  // One comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a new instruction and operands away from the rising edge, then let
  // the combinational outputs settle.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clock);
    busIf.instruction = instr;
    busIf.rs1_data    = a;
    busIf.rs2_data    = b;
    #1;
  endtask

  // Let one rising edge capture the writeback register, then sample.
  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  // Reference: which operation the instruction asks for, from the opcode rules.
  function automatic logic [3:0] refAluOp(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    if (i[6:0] == 7'h33) return {i[30], f3};
    if (i[6:0] == 7'h13) return (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
    return 4'd0;
  endfunction

  // Reference ALU written with plain integer arithmetic.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint unsigned ua, ub, pow2;
    longint sa, sb;
    ua   = longint'(a);
    ub   = longint'(b);
    pow2 = 64'd1 << b[4:0];
    sa   = a[31] ? (longint'(a) - 64'sh1_0000_0000) : longint'(a);
    sb   = b[31] ? (longint'(b) - 64'sh1_0000_0000) : longint'(b);
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd8:  return 32'(ua + (64'h1_0000_0000 - ub));
      4'd1:  return 32'(ua * pow2);
      4'd5:  return 32'(ua / pow2);
      4'd13: return a[31] ? ~32'((longint'(~a)) / pow2) : 32'(ua / pow2);
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refIllegal(input logic [6:0] opc);
`ifdef DECODE_ILLEGAL_EN
    return !(opc inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F});
`else
    return 1'b0;
`endif
  endfunction

  logic [6:0] opcodePool [12];

  initial begin
    logic [31:0] instr, a, b, bEff, expOut;
    logic [3:0]  expOp;
    logic        expEn;

    opcodePool = '{7'h33, 7'h13, 7'h33, 7'h13, 7'h03, 7'h37,
                   7'h17, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h7F};

    // Reset state, with an instruction present to show decode ignores reset.
    busIf.instruction = 32'd0;
    busIf.rs1_data    = 32'd0;
    busIf.rs2_data    = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset wb_data_q", busIf.wb_data_q, 32'd0);
    checkOutput("reset wb_rd_q",   32'(busIf.wb_rd_q), 32'd0);
    checkOutput("reset wb_en_q",   32'(busIf.wb_en_q), 32'd0);
    applyStimulus(32'hFFF00093, 32'd0, 32'd0);
    checkOutput("alu_out during reset", busIf.alu_out, 32'hFFFFFFFF);
    stepClock();
    checkOutput("wb_en_q held in reset", 32'(busIf.wb_en_q), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // addi x1,x0,-1
    applyStimulus(32'hFFF00093, 32'd0, 32'd0);
    checkOutput("addi imm12",   busIf.imm12, 32'hFFFFFFFF);
    checkOutput("addi alu_op",  32'(busIf.alu_op), 32'd0);
    checkOutput("addi alu_out", busIf.alu_out, 32'hFFFFFFFF);
    stepClock();
    checkOutput("addi wb_rd_q",   32'(busIf.wb_rd_q), 32'd1);
    checkOutput("addi wb_en_q",   32'(busIf.wb_en_q), 32'd1);
    checkOutput("addi wb_data_q", busIf.wb_data_q, 32'hFFFFFFFF);

    // sub x3,x1,x2
    applyStimulus(32'h402081B3, 32'd5, 32'd7);
    checkOutput("sub alu_op",  32'(busIf.alu_op), 32'd8);
    checkOutput("sub alu_out", busIf.alu_out, 32'hFFFFFFFE);

    // srai x5,x6,4
    applyStimulus(32'h40435293, 32'h80000000, 32'd0);
    checkOutput("srai alu_op",  32'(busIf.alu_op), 32'd13);
    checkOutput("srai alu_out", busIf.alu_out, 32'hF8000000);

    // slt / sltu x1,x2,x3 with a=-1, b=1
    applyStimulus(32'h003120B3, 32'hFFFFFFFF, 32'd1);
    checkOutput("slt alu_out", busIf.alu_out, 32'd1);
    applyStimulus(32'h003130B3, 32'hFFFFFFFF, 32'd1);
    checkOutput("sltu alu_out", busIf.alu_out, 32'd0);

    // Immediate forms
    applyStimulus(32'hFF9FF0EF, 32'd0, 32'd0);
    checkOutput("jal jal_offset", busIf.jal_offset, 32'hFFFFFFF8);
    applyStimulus(32'h123453B7, 32'd0, 32'd0);
    checkOutput("lui imm20", busIf.imm20, 32'h12345000);
    stepClock();
    checkOutput("lui wb_en_q", 32'(busIf.wb_en_q), 32'd0);
    applyStimulus(32'hFE20AE23, 32'd0, 32'd0);
    checkOutput("sw store_offset", busIf.store_offset, 32'hFFFFFFFC);

    // addi x0,x0,5 must not write back
    applyStimulus(32'h00500013, 32'd0, 32'd0);
    stepClock();
    checkOutput("addi x0 wb_en_q", 32'(busIf.wb_en_q), 32'd0);
    checkOutput("addi x0 wb_data_q", busIf.wb_data_q, 32'd5);

    // Reset mid-stream discards the in-flight result
    applyStimulus(32'hFFF00093, 32'd0, 32'd0);
    reset = 1'b1;
    stepClock();
    checkOutput("midreset wb_data_q", busIf.wb_data_q, 32'd0);
    checkOutput("midreset wb_rd_q",   32'(busIf.wb_rd_q), 32'd0);
    checkOutput("midreset wb_en_q",   32'(busIf.wb_en_q), 32'd0);
    reset = 1'b0;
    applyStimulus(32'h402081B3, 32'd5, 32'd7);
    stepClock();
    checkOutput("post-reset wb_data_q", busIf.wb_data_q, 32'hFFFFFFFE);
    checkOutput("post-reset wb_rd_q",   32'(busIf.wb_rd_q), 32'd3);
    checkOutput("post-reset wb_en_q",   32'(busIf.wb_en_q), 32'd1);

    // Unsupported opcode 0x7F, rd=1
    applyStimulus(32'h000000FF, 32'd1, 32'd1);
`ifdef DECODE_ILLEGAL_EN
    checkOutput("0x7F illegal", 32'(busIf.illegal), 32'd1);
`else
    checkOutput("0x7F illegal", 32'(busIf.illegal), 32'd0);
`endif
    stepClock();
    checkOutput("0x7F wb_en_q", 32'(busIf.wb_en_q), 32'd0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 60; n++) begin
      instr = $urandom;
      instr[6:0] = opcodePool[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      bEff   = (instr[6:0] == 7'h13) ? {{20{instr[31]}}, instr[31:20]} : b;
      expOp  = refAluOp(instr);
      expOut = refAlu(expOp, a, bEff);
      expEn  = ((instr[6:0] == 7'h33) || (instr[6:0] == 7'h13)) &&
               (instr[11:7] != 5'd0) && !refIllegal(instr[6:0]);

      applyStimulus(instr, a, b);
      checkOutput("rnd opcode", 32'(busIf.opcode), 32'(instr[6:0]));
      checkOutput("rnd rs1",    32'(busIf.rs1), 32'(instr[19:15]));
      checkOutput("rnd rs2",    32'(busIf.rs2), 32'(instr[24:20]));
      checkOutput("rnd funct3", 32'(busIf.funct3), 32'(instr[14:12]));
      checkOutput("rnd alu_op", 32'(busIf.alu_op), 32'(expOp));
      checkOutput("rnd alu_out", busIf.alu_out, expOut);
      checkOutput("rnd illegal", 32'(busIf.illegal), 32'(refIllegal(instr[6:0])));
      checkOutput("rnd imm12", busIf.imm12, {{20{instr[31]}}, instr[31:20]});
      checkOutput("rnd jalr_offset", busIf.jalr_offset, {{20{instr[31]}}, instr[31:20]});
      checkOutput("rnd imm20", busIf.imm20, {instr[31:12], 12'h000});
      checkOutput("rnd store_offset", busIf.store_offset,
                  {{20{instr[31]}}, instr[31:25], instr[11:7]});
      checkOutput("rnd branch_offset", busIf.branch_offset,
                  {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      checkOutput("rnd jal_offset", busIf.jal_offset,
                  {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      stepClock();
      checkOutput("rnd wb_data_q", busIf.wb_data_q, expOut);
      checkOutput("rnd wb_rd_q",   32'(busIf.wb_rd_q), 32'(instr[11:7]));
      checkOutput("rnd wb_en_q",   32'(busIf.wb_en_q), 32'(expEn));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
